// File: rtl/ats_dequeue_ctrl.sv
// ATS dequeue controller: one dequeue per selector win, waits tx_done, then holds off PIPE_LAT cycles.
// Latency: deq_valid 1 cycle after a qualifying select; request held until deq_ready, one outstanding max.
module ats_dequeue_ctrl #(
    parameter int PIPE_LAT       = 4,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           sel_index,
    input  logic                 sel_flag,
    input  logic [2:0]           queue_empty,
    input  logic                 tx_enable,
    output logic                 deq_valid,
    output logic [1:0]           deq_queue_id,
    input  logic                 deq_ready,
    input  logic                 tx_done,
    output logic                 busy,
    output logic                 err_timeout,
    output logic                 err_bad_index,
    output logic [CNT_WIDTH-1:0] deq_count_0,
    output logic [CNT_WIDTH-1:0] deq_count_1,
    output logic [CNT_WIDTH-1:0] deq_count_2
);

    localparam int TMAX = (TIMEOUT_CYCLES > PIPE_LAT) ? TIMEOUT_CYCLES : PIPE_LAT;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_TX, HOLDOFF} state_t;

    state_t               state;
    logic [TW-1:0]        timer;
    logic [CNT_WIDTH-1:0] deq_cnt [3];
    logic [3:0]           empty_ext;
    logic                 launch_ok;

    // Index 3 maps onto a permanently "empty" slot so it can never launch.
    assign empty_ext = {1'b1, queue_empty};
    assign launch_ok = sel_flag && (sel_index != 2'd3) && !empty_ext[sel_index] && tx_enable;
    assign busy      = (state != IDLE);

    assign deq_count_0 = deq_cnt[0];
    assign deq_count_1 = deq_cnt[1];
    assign deq_count_2 = deq_cnt[2];

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            timer         <= '0;
            deq_valid     <= 1'b0;
            deq_queue_id  <= 2'd0;
            err_timeout   <= 1'b0;
            err_bad_index <= 1'b0;
            for (int i = 0; i < 3; i++) deq_cnt[i] <= '0;
        end else begin
            err_timeout   <= 1'b0;
            err_bad_index <= 1'b0;
            case (state)
                IDLE: begin
                    if (launch_ok) begin
                        deq_queue_id <= sel_index;
                        deq_valid    <= 1'b1;
                        state        <= REQ;
                    end else if (sel_flag && sel_index == 2'd3) begin
                        err_bad_index <= 1'b1;
                    end
                end
                REQ: begin
                    if (deq_ready) begin
                        deq_valid <= 1'b0;
                        timer     <= '0;
                        state     <= WAIT_TX;
                        for (int i = 0; i < 3; i++) begin
                            if (deq_queue_id == 2'(i) && deq_cnt[i] != '1)
                                deq_cnt[i] <= deq_cnt[i] + CNT_WIDTH'(1);
                        end
                    end
                end
                WAIT_TX: begin
                    // tx_done takes priority over a coincident timeout.
                    if (tx_done) begin
                        timer <= '0;
                        state <= HOLDOFF;
                    end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
                        err_timeout <= 1'b1;
                        timer       <= '0;
                        state       <= HOLDOFF;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                HOLDOFF: begin
                    if (timer == TW'(PIPE_LAT - 1)) begin
                        timer <= '0;
                        state <= IDLE;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ats_dequeue_ctrl.sv
// Directed bench for ats_dequeue_ctrl with PIPE_LAT=4, TIMEOUT_CYCLES=16, CNT_WIDTH=4.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_ats_dequeue_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] sel_index;
    logic       sel_flag;
    logic [2:0] queue_empty;
    logic       tx_enable;
    logic       deq_valid;
    logic [1:0] deq_queue_id;
    logic       deq_ready;
    logic       tx_done;
    logic       busy;
    logic       err_timeout;
    logic       err_bad_index;
    logic [3:0] deq_count_0, deq_count_1, deq_count_2;

    int n_chk = 0;
    int n_bad = 0;
    int n_vld = 0;

    ats_dequeue_ctrl #(.PIPE_LAT(4), .TIMEOUT_CYCLES(16), .CNT_WIDTH(4)) dut (
        .clk(clk), .reset(reset), .sel_index(sel_index), .sel_flag(sel_flag),
        .queue_empty(queue_empty), .tx_enable(tx_enable), .deq_valid(deq_valid),
        .deq_queue_id(deq_queue_id), .deq_ready(deq_ready), .tx_done(tx_done),
        .busy(busy), .err_timeout(err_timeout), .err_bad_index(err_bad_index),
        .deq_count_0(deq_count_0), .deq_count_1(deq_count_1), .deq_count_2(deq_count_2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse tx_done for one cycle, then walk through the 4-cycle hold-off.
    task automatic finish_tx();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        repeat (4) step();
    endtask

    initial begin
        reset = 1'b1; sel_index = 2'd0; sel_flag = 1'b0; queue_empty = 3'b000;
        tx_enable = 1'b1; deq_ready = 1'b0; tx_done = 1'b0;
        step(); step();
        chk("rst_valid", deq_valid, 0);
        chk("rst_id", deq_queue_id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_errs", {err_timeout, err_bad_index}, 0);
        chk("rst_cnts", {deq_count_0, deq_count_1, deq_count_2}, 0);
        reset = 1'b0;
        step();

        // Basic launch on queue 1 with immediate ready.
        sel_flag = 1'b1; sel_index = 2'd1; deq_ready = 1'b1;
        step();
        chk("basic_valid", deq_valid, 1);
        chk("basic_id", deq_queue_id, 1);
        chk("basic_busy", busy, 1);
        sel_flag = 1'b0;
        step();
        chk("basic_valid_1cyc", deq_valid, 0);
        chk("basic_cnt1", deq_count_1, 1);
        repeat (9) step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        repeat (3) step();
        chk("basic_busy_hold3", busy, 1);
        step();
        chk("basic_busy_drop4", busy, 0);

        // Backpressure: request on queue 0 held while selector index wanders.
        deq_ready = 1'b0; sel_flag = 1'b1; sel_index = 2'd0;
        step();
        chk("bp_launch_id", deq_queue_id, 0);
        for (int i = 0; i < 7; i++) begin
            sel_index = (i % 2 == 0) ? 2'd2 : 2'd0;
            step();
            chk("bp_hold_valid", deq_valid, 1);
            chk("bp_hold_id", deq_queue_id, 0);
        end
        chk("bp_cnt_before", deq_count_0, 0);
        deq_ready = 1'b1; sel_flag = 1'b0;
        step();
        chk("bp_valid_drop", deq_valid, 0);
        chk("bp_cnt_after", deq_count_0, 1);
        finish_tx();

        // Hold-off: selector keeps asserting queue 0 throughout.
        sel_flag = 1'b1; sel_index = 2'd0;
        step();
        chk("ho_launch", deq_valid, 1);
        step(); step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        n_vld = 0;
        for (int i = 0; i < 4; i++) begin
            if (deq_valid) n_vld++;
            step();
        end
        chk("ho_no_valid", n_vld, 0);
        chk("ho_idle_cycle_valid", deq_valid, 0);
        chk("ho_idle_cycle_busy", busy, 0);
        step();
        chk("ho_relaunch", deq_valid, 1);
        sel_flag = 1'b0;
        step();
        chk("ho_cnt0", deq_count_0, 3);
        finish_tx();

        // Gating and index errors while idle.
        sel_flag = 1'b1; sel_index = 2'd3;
        step();
        chk("bad_idx_pulse", err_bad_index, 1);
        chk("bad_idx_noreq", deq_valid, 0);
        sel_flag = 1'b0;
        step();
        chk("bad_idx_single", err_bad_index, 0);
        sel_flag = 1'b1; sel_index = 2'd2; queue_empty = 3'b100;
        step();
        chk("empty_noreq", {deq_valid, busy, err_bad_index}, 0);
        queue_empty = 3'b000; tx_enable = 1'b0;
        step();
        chk("gate_noreq", {deq_valid, busy}, 0);
        sel_flag = 1'b0; tx_enable = 1'b1;
        step();

        // Timeout with no tx_done.
        sel_flag = 1'b1; sel_index = 2'd2;
        step();
        sel_flag = 1'b0;
        step();
        chk("to_cnt2", deq_count_2, 1);
        repeat (15) step();
        chk("to_before", {busy, err_timeout}, 2'b10);
        step();
        chk("to_pulse", err_timeout, 1);
        step();
        chk("to_single", err_timeout, 0);
        step(); step();
        chk("to_holdoff_busy", busy, 1);
        step();
        chk("to_idle", busy, 0);

        // tx_done coinciding with the timeout cycle: no error.
        sel_flag = 1'b1;
        step();
        sel_flag = 1'b0;
        step();
        repeat (15) step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        chk("to_coincide_noerr", err_timeout, 0);
        repeat (4) step();
        chk("to_coincide_idle", busy, 0);

        // Reset while a request is pending.
        deq_ready = 1'b0; sel_flag = 1'b1; sel_index = 2'd1;
        step();
        chk("rreq_valid", deq_valid, 1);
        reset = 1'b1; sel_flag = 1'b0;
        step();
        chk("rreq_valid_drop", {deq_valid, busy}, 0);
        chk("rreq_cnts", {deq_count_0, deq_count_1, deq_count_2}, 0);
        chk("rreq_errs", {err_timeout, err_bad_index}, 0);
        reset = 1'b0; deq_ready = 1'b1;
        step();

        // Saturation: 17 dequeues on queue 2 with a 4-bit counter.
        for (int i = 0; i < 17; i++) begin
            sel_flag = 1'b1; sel_index = 2'd2;
            step();
            sel_flag = 1'b0;
            step();
            if (i == 14) chk("sat_at15", deq_count_2, 15);
            finish_tx();
        end
        chk("sat_cnt2", deq_count_2, 15);
        chk("sat_other", {deq_count_0, deq_count_1}, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/ats_dequeue_ctrl.md
Name: ats_dequeue_ctrl

Overview:
Consumer side of the ATS minimum-eligibility selector. It takes the per-cycle selected queue index and eligible flag, issues one dequeue request to the chosen queue through a valid/ready handshake, and waits for frame transmission to complete. It then applies a hold-off window so that stale selector results still in the selector pipeline are never acted on. The block sits between the eligibility selector and the queue manager / egress MAC of one output port.

Parameters:
PIPE_LAT, 4, selector latency in cycles; number of hold-off cycles after each transmission.
TIMEOUT_CYCLES, 4096, maximum cycles spent waiting for tx_done before abort.
CNT_WIDTH, 16, width of the per-queue dequeue statistics counters.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
sel_index  in  2  selected queue index from eligibility selector (0..2)
sel_flag  in  1  selected queue is eligible (head eligibility time <= local clock)
queue_empty  in  3  per-queue empty status, bit i = queue i
tx_enable  in  1  port allowed to start a new frame (gate closed = 0)
deq_valid  out  1  dequeue request valid
deq_queue_id  out  2  queue to dequeue; stable while deq_valid=1
deq_ready  in  1  queue manager accepts request
tx_done  in  1  single-cycle pulse: dequeued frame fully transmitted
busy  out  1  high in every state except IDLE
err_timeout  out  1  single-cycle pulse on tx_done timeout
err_bad_index  out  1  single-cycle pulse when sel_flag=1 with sel_index=3 in IDLE
deq_count_0/1/2  out  CNT_WIDTH each  saturating count of accepted dequeues per queue

Behaviour:
- Reset values: deq_valid=0, deq_queue_id=0, busy=0, err_timeout=0, err_bad_index=0, all deq_count=0, FSM=IDLE, timers=0. Reset wins over every other event in the same cycle. Reset mid-transaction drops deq_valid at the next edge with no completion or error pulse.
- FSM states: IDLE, REQ, WAIT_TX, HOLDOFF.
- IDLE: launch when sel_flag=1, sel_index<=2, queue_empty[sel_index]=0 and tx_enable=1. On the launch edge: latch deq_queue_id<=sel_index, deq_valid<=1, go to REQ. deq_valid is therefore high 1 cycle after the qualifying inputs are sampled.
- IDLE with sel_flag=1 and sel_index=3: no launch; err_bad_index pulses for 1 cycle.
- IDLE with sel_flag=1 and the selected queue empty, or tx_enable=0: no action, no error.
- REQ: deq_valid and deq_queue_id are held until deq_ready=1. On the handshake edge: deq_valid<=0, deq_count[id] increments (saturates at all-ones), timer cleared, go to WAIT_TX. If deq_ready is already 1 in the first REQ cycle, the handshake completes in that cycle. There is no abort from REQ; sel_*, tx_enable and queue_empty are ignored.
- WAIT_TX: timer increments each cycle.
  - tx_done=1: go to HOLDOFF, timer cleared.
  - Otherwise, when timer reaches TIMEOUT_CYCLES-1: err_timeout pulses, go to HOLDOFF.
  - If tx_done and the timeout coincide, tx_done wins and there is no error.
- HOLDOFF: stays exactly PIPE_LAT cycles with sel_flag ignored, then goes to IDLE. The first sel_flag that can cause a launch is the one sampled in the first IDLE cycle.
- tx_done is ignored in IDLE, REQ and HOLDOFF.
- deq_ready is ignored when deq_valid=0.
- busy is combinationally (state != IDLE).
- At most one outstanding dequeue at any time.

Test Plan:
- Basic launch: sel_flag=1, sel_index=1, queue_empty=000, tx_enable=1, deq_ready=1 -> deq_valid=1 with id=1 for exactly 1 cycle; deq_count_1=1. tx_done 10 cycles later -> busy drops exactly 4 cycles after tx_done (PIPE_LAT=4).
- Backpressure: deq_ready held 0 for 7 cycles while sel_index toggles 0/2 -> deq_valid stays 1 with id fixed at the launch value; count increments once, on the deq_ready=1 edge.
- Hold-off: sel_flag=1, sel_index=0 held constantly -> dequeues are spaced by tx_done latency + PIPE_LAT + 1 IDLE cycle; no extra deq_valid during HOLDOFF.
- Gating and errors: in IDLE, sel_index=3 with sel_flag=1 -> one err_bad_index pulse, no request. queue_empty=100 with sel_index=2 -> no request. tx_enable=0 -> no request.
- Timeout: TIMEOUT_CYCLES=16, no tx_done -> err_timeout pulses on the 16th WAIT_TX cycle, then HOLDOFF, then IDLE. tx_done in the same cycle as the timeout -> no error.
- Reset and saturation: assert reset during REQ -> next cycle deq_valid=0, busy=0, counts=0. CNT_WIDTH=4 with 17 dequeues on queue 2 -> deq_count_2=15.
